// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if : data-memory request/response bundle between the EX/MEM stage
//           (initiator) and the data-memory responder.
//
// Signals:
//   mem_read  initiator -> responder  load request
//   mem_write initiator -> responder  store request
//   func3     initiator -> responder  access size/sign (RISC-V encoding)
//   addr      initiator -> responder  byte address
//   wdata     initiator -> responder  store data
//   rdata     responder -> initiator  load result (registered, valid in DONE)
//   stall     responder -> initiator  pipeline freeze request
//   err       responder -> initiator  access-fault pulse (valid in DONE)
// ----------------------------------------------------------------------------
interface dmem_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    modport master (
        output mem_read, mem_write, func3, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  mem_read, mem_write, func3, addr, wdata,
        output rdata, stall, err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder : multi-cycle byte-addressed data memory for a pipelined core.
//
// Each load/store occupies IDLE -> BUSY (LATENCY cycles) -> DONE. The request
// is captured in IDLE; the array is accessed on the edge that leaves BUSY, and
// the registered result (rdata/err) is visible only while in DONE.
//
// Parameters:
//   DEPTH_BYTES  memory size in bytes (power of two), address wraps modulo it
//   LATENCY      busy cycles per access (1..15)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (memory contents are preserved)
//   bus    dmem_if.slave : mem_read, mem_write, func3, addr, wdata in;
//                          rdata, stall, err out
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses are
//                          faulted (no access, err=1). When undefined, the low
//                          address bits are forced to the natural alignment.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_BYTES = 512,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic [IDX_W-1:0]   addr_r;
    logic [31:0]        wdata_r;
    logic [2:0]         func3_r;
    logic               rd_r;
    logic               wr_r;
    logic [31:0]        rdata_r;
    logic               err_r;

    logic [7:0]         mem_r [DEPTH_BYTES];

    logic               req_s;
    size_t              size_s;
    logic               illegal_s;
    logic               fault_s;
    logic [IDX_W-1:0]   idx0_s;
    logic [IDX_W-1:0]   idx1_s;
    logic [IDX_W-1:0]   idx2_s;
    logic [IDX_W-1:0]   idx3_s;
    logic [31:0]        load_s;
    logic               access_s;
    logic               we_s;
    logic               unused_addr_s;

    assign req_s         = bus.mem_read | bus.mem_write;
    // Address bits above the array index never select anything.
    assign unused_addr_s = ^bus.addr[31:IDX_W];

    // Decode access size, fault conditions and the aligned byte indices.
    always_comb begin
        size_s    = SZ_BYTE;
        illegal_s = 1'b0;
        case (func3_r)
            3'b000, 3'b100: size_s = SZ_BYTE;
            3'b001, 3'b101: size_s = SZ_HALF;
            3'b010:         size_s = SZ_WORD;
            default:        illegal_s = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        idx0_s  = addr_r;
        fault_s = (rd_r & wr_r) | illegal_s |
                  ((size_s == SZ_HALF) & addr_r[0]) |
                  ((size_s == SZ_WORD) & (addr_r[1:0] != 2'b00));
`else
        fault_s = (rd_r & wr_r) | illegal_s;
        if (size_s == SZ_HALF) begin
            idx0_s = {addr_r[IDX_W-1:1], 1'b0};
        end else if (size_s == SZ_WORD) begin
            idx0_s = {addr_r[IDX_W-1:2], 2'b00};
        end else begin
            idx0_s = addr_r;
        end
`endif
        // Index arithmetic wraps naturally at the array size.
        idx1_s = idx0_s + IDX_W'(1);
        idx2_s = idx0_s + IDX_W'(2);
        idx3_s = idx0_s + IDX_W'(3);
    end

    // Assemble little-endian load data with sign or zero extension.
    always_comb begin
        load_s = 32'd0;
        case (size_s)
            SZ_BYTE: load_s = {{24{~func3_r[2] & mem_r[idx0_s][7]}}, mem_r[idx0_s]};
            SZ_HALF: load_s = {{16{~func3_r[2] & mem_r[idx1_s][7]}},
                               mem_r[idx1_s], mem_r[idx0_s]};
            SZ_WORD: load_s = {mem_r[idx3_s], mem_r[idx2_s], mem_r[idx1_s], mem_r[idx0_s]};
            default: load_s = 32'd0;
        endcase
    end

    assign access_s  = (state_r == BUSY) && (cnt_r == 4'd0);
    assign we_s      = access_s & wr_r & ~fault_s;
    // Reset moves the FSM out of BUSY asynchronously, so an aborted store
    // can never reach the write edge.
    assign bus.stall = ((state_r == IDLE) & req_s) | (state_r == BUSY);
    assign bus.rdata = rdata_r;
    assign bus.err   = err_r;

    // Access sequencer: request capture, latency countdown, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            func3_r <= 3'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rdata_r <= 32'd0;
                    err_r   <= 1'b0;
                    if (req_s) begin
                        addr_r  <= bus.addr[IDX_W-1:0];
                        wdata_r <= bus.wdata;
                        func3_r <= bus.func3;
                        rd_r    <= bus.mem_read;
                        wr_r    <= bus.mem_write;
                        cnt_r   <= 4'(LATENCY - 1);
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r   <= cnt_r - 4'd1;
                        rdata_r <= 32'd0;
                        err_r   <= 1'b0;
                    end else begin
                        state_r <= DONE;
                        err_r   <= fault_s;
                        rdata_r <= (rd_r & ~wr_r & ~fault_s) ? load_s : 32'd0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    rdata_r <= 32'd0;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    rdata_r <= 32'd0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[idx0_s] <= wdata_r[7:0];
            if (size_s != SZ_BYTE) begin
                mem_r[idx1_s] <= wdata_r[15:8];
            end
            if (size_s == SZ_WORD) begin
                mem_r[idx2_s] <= wdata_r[23:16];
                mem_r[idx3_s] <= wdata_r[31:24];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder : self-checking bench for dmem_responder (LATENCY=2,
// DEPTH_BYTES=512). Directed table of scenarios, a reset-abort sequence and
// randomized accesses checked against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_dmem_responder;
    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dmem_if bus ();

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model storage: one byte per address.
    logic [7:0] mm [DEPTH];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Behavioural model: applies the access rules to the byte array.
    task automatic ref_model(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] er, output logic ee);
        int unsigned size;
        int unsigned base;
        logic [31:0] v;
        er = 32'd0;
        ee = 1'b0;
        size = 1 << f3[1:0];
        if ((rd && wr) || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
            ee = 1'b1;
            return;
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % size != 0) begin
            ee = 1'b1;
            return;
        end
        base = a % DEPTH;
`else
        base = (a - (a % size)) % DEPTH;
`endif
        if (wr) begin
            for (int i = 0; i < int'(size); i++) mm[(base + i) % DEPTH] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(mm[(base + i) % DEPTH]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            er = v;
        end
    endtask

    // Present one request, wait for DONE, return result and stall length.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] r, output logic e, output int n);
        logic bad;
        bad = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.func3     = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        n = 0;
        @(negedge clk);
        while (bus.stall === 1'b1 && n < 40) begin
            n++;
            if (bus.rdata !== 32'd0 || bus.err !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        r = bus.rdata;
        e = bus.err;
        chk("quiet_while_stalled", 32'(bad), 32'd0);
    endtask

    task automatic run_one(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee);
        logic [31:0] r;
        logic        e;
        int          n;
        access(rd, wr, f3, a, wd, r, e, n);
        chk({nm, "_stall_len"}, 32'(n), 32'(LAT + 1));
        chk({nm, "_rdata"}, r, er);
        chk({nm, "_err"}, 32'(e), 32'(ee));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_rdata", bus.rdata, 32'd0);
        chk("idle_err", 32'(bus.err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          sel;

        checks   = 0;
        failures = 0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.func3     = 3'd0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        rst_n = 1'b0;

        vt[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1};
`else
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h12,  32'h0,        32'hDEADBEEF, 1'b0};
`endif
        vt[6]  = '{1'b0, 1'b1, 3'b000, 32'h211, 32'h0000005A, 32'h0,        1'b0};
        vt[7]  = '{1'b1, 1'b0, 3'b100, 32'h011, 32'h0,        32'h0000005A, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 3'b010, 32'h30,  32'hFFFFFFFF, 32'h0,        1'b1};
        vt[9]  = '{1'b1, 1'b0, 3'b010, 32'h30,  32'h0,        32'hA5000030, 1'b0};
        vt[10] = '{1'b1, 1'b0, 3'b011, 32'h40,  32'h0,        32'h0,        1'b1};
        vt[11] = '{1'b0, 1'b1, 3'b110, 32'h40,  32'h0,        32'h0,        1'b1};
        vt[12] = '{1'b1, 1'b0, 3'b010, 32'h40,  32'h0,        32'hA5000040, 1'b0};
        vt[13] = '{1'b0, 1'b1, 3'b001, 32'h44,  32'h12348001, 32'h0,        1'b0};
        vt[14] = '{1'b1, 1'b0, 3'b010, 32'h44,  32'h0,        32'hA5008001, 1'b0};
        vt[15] = '{1'b1, 1'b0, 3'b101, 32'h46,  32'h0,        32'h0000A500, 1'b0};
        vt[16] = '{1'b0, 1'b1, 3'b010, 32'h1FC, 32'h01020304, 32'h0,        1'b0};
        vt[17] = '{1'b1, 1'b0, 3'b000, 32'h3FF, 32'h0,        32'h00000001, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Fill memory with a known pattern: word at a = 0xA5000000 | a
        for (int w = 0; w < DEPTH / 4; w++) begin
            ref_model(1'b0, 1'b1, 3'b010, 32'(w * 4), 32'hA500_0000 | 32'(w * 4), er, ee);
            run_one("init_sw", 1'b0, 1'b1, 3'b010, 32'(w * 4), 32'hA500_0000 | 32'(w * 4), er, ee);
        end

        // Directed table, back-to-back
        for (int i = 0; i < NV; i++) begin
            ref_model(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].wd, er, ee);
            run_one($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].wd,
                    vt[i].er, vt[i].ee);
        end
        idle_cycle();

        // Reset during the second stall cycle of a store aborts it
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b1;
        bus.func3     = 3'b010;
        bus.addr      = 32'h20;
        bus.wdata     = 32'h12345678;
        @(negedge clk);
        chk("abort_stall_c1", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        chk("abort_stall_c2", 32'(bus.stall), 32'd1);
        #2;
        rst_n = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        chk("abort_stall_in_reset", 32'(bus.stall), 32'd0);
        chk("abort_rdata_in_reset", bus.rdata, 32'd0);
        chk("abort_err_in_reset", 32'(bus.err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_one("abort_lw", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5000020, 1'b0);
        idle_cycle();

        // Randomized accesses against the reference model
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel < 5);
            wr  = (sel >= 5) || (sel == 0);
            f3  = 3'($urandom_range(0, 7));
            a   = 32'($urandom_range(0, 1023));
            wd  = $urandom;
            ref_model(rd, wr, f3, a, wd, er, ee);
            run_one("rand", rd, wr, f3, a, wd, er, ee);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock `clk`; reset `rst_n` SHALL be asynchronous and active-low.
REQ-002 Parameter: DEPTH_BYTES, default 512, memory size in bytes (power of two).
REQ-003 Parameter: LATENCY, default 2, extra busy cycles per access (legal range 1..15).
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: mem_read  in  1  load request from the EX/MEM stage register.
REQ-007 Port: mem_write  in  1  store request from the EX/MEM stage register.
REQ-008 Port: func3  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 Port: addr  in  32  byte address (ALU result).
REQ-010 Port: wdata  in  32  store data (rs2 value).
REQ-011 Port: rdata  out  32  load result, registered, valid in DONE.
REQ-012 Port: stall  out  1  freeze request to IF/ID/EX stages and the EX/MEM register.
REQ-013 Port: err  out  1  access-fault pulse, valid in DONE.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE and SHALL reset to IDLE.
REQ-015 IDLE: with req = mem_read|mem_write high, the block SHALL latch addr/wdata/func3/type, load cnt=LATENCY-1 and go to BUSY; with req low, it SHALL stay in IDLE.
REQ-016 BUSY: while cnt!=0 the block SHALL decrement cnt; at cnt==0 it SHALL perform the access on that edge and go to DONE.
REQ-017 DONE: the block SHALL go unconditionally to IDLE and SHALL NOT accept a request in this state.
REQ-018 stall SHALL equal (IDLE & req) | BUSY, combinationally, so it is high for exactly LATENCY+1 consecutive cycles per access.
REQ-019 The initiator SHALL hold its inputs stable while stall is high; the block SHALL use only the latched copies after IDLE.
REQ-020 Back-to-back requests: a new instruction presented in the cycle after DONE SHALL start normally from IDLE.
REQ-021 Loads: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; byte order SHALL be little-endian.
REQ-022 Stores: SB/SH/SW SHALL write 1/2/4 bytes; rdata SHALL be 0 in DONE after a store.
REQ-023 The array index SHALL be addr modulo DEPTH_BYTES, wrapping with no fault.
REQ-024 If mem_read and mem_write are both high, the block SHALL perform no access and SHALL assert err in DONE.
REQ-025 If func3 is 011, 110 or 111, the block SHALL perform no access and SHALL assert err in DONE.
REQ-026 err and rdata SHALL hold their values only during DONE and SHALL be 0 in every other state.

Reset
REQ-027 With rst_n low, the block SHALL enter IDLE immediately with stall=0 (absent req), rdata=0, err=0 and cnt=0.
REQ-028 Reset in BUSY SHALL abort the access, and a pending store SHALL NOT modify memory.
REQ-029 Reset SHALL NOT clear the memory array contents.

Configuration
REQ-030 The macro DMEM_MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-031 Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL perform no access, SHALL return rdata=0 and SHALL assert err in DONE.
REQ-032 Undefined: for alignment purposes only, the block SHALL clear addr[0] for halfword accesses and addr[1:0] for word accesses, and SHALL never raise err for alignment.

Verification (LATENCY=2)
REQ-033 Scenario: SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> stall high 3 cycles each; rdata=0xDEADBEEF in DONE; err=0.
REQ-034 Scenario: LB 0x13 and LBU 0x13 after REQ-033 -> rdata 0xFFFFFFDE and 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
REQ-035 Scenario: SB 0x211 data 0x5A, then LBU 0x011 (DEPTH_BYTES=512) -> rdata 0x0000005A (wrap).
REQ-036 Scenario: LW 0x12 -> with macro: err=1, rdata=0; without macro: rdata equals the word at 0x10, err=0.
REQ-037 Scenario: SW 0x20 0x12345678 with rst_n pulsed low in the 2nd stall cycle, then LW 0x20 -> stall drops during reset and the old contents of 0x20 are returned.
REQ-038 Scenario: mem_read=mem_write=1 at 0x30 -> err=1 in DONE; a following LW 0x30 shows the location unchanged.
